// File: rtl/corriente_ramp_ctrl_pkg.sv
// ============================================================================
//  Module      : corriente_ramp_ctrl_pkg
//  Description : Shared definitions for the current-setting sequencer.
//                Holds the setting width, the default top setting and the
//                controller state encoding. The lookup table and the display
//                logic reuse the same definitions.
//  Contents    : SET_W        - width of a current setting (0..MAX_STEP)
//                MAX_STEP_DEF - default highest legal setting
//                ramp_state_e - controller states (IDLE/RAMP_UP/RAMP_DOWN/STOP)
//                is_ramp_state- true for the two ramping states
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package corriente_ramp_ctrl_pkg;

    localparam int SET_W        = 4;
    localparam int MAX_STEP_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_STOP      = 2'd3
    } ramp_state_e;

    function automatic logic is_ramp_state(input ramp_state_e s);
        return (s == ST_RAMP_UP) || (s == ST_RAMP_DOWN);
    endfunction

endpackage : corriente_ramp_ctrl_pkg

`default_nettype wire

// File: rtl/corriente_tick_gen.sv
// ============================================================================
//  Module      : corriente_tick_gen
//  Description : Ramp step timer. Counts 0..RAMP_DIV-1 while enabled and
//                flags the last count with a single-clock tick, then wraps.
//                A clear returns the count to 0 and takes priority over the
//                enable, so any partial count is discarded.
//  Ports       : clk     in  system clock
//                rst_n   in  asynchronous active-low reset
//                en_i    in  count enable
//                clr_i   in  synchronous clear to 0 (priority over en_i)
//                tick_o  out high for the clock where the count is RAMP_DIV-1
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module corriente_tick_gen
    import corriente_ramp_ctrl_pkg::*;
#(
    parameter int RAMP_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(RAMP_DIV - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_at_last;

    assign w_at_last = (cnt_q == C_LAST);
    assign tick_o    = en_i & w_at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = w_at_last ? '0 : (cnt_q + C_ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : corriente_tick_gen

`default_nettype wire

// File: rtl/corriente_ramp_ctrl.sv
// ============================================================================
//  Module      : corriente_ramp_ctrl
//  Description : Current-setting sequencer. Keeps a user target driven by
//                up/down button pulses and walks the applied setting one
//                step per RAMP_DIV clocks toward it, so the load never sees
//                a jump larger than one table step. An emergency stop forces
//                both applied and target settings to 0 on the next edge.
//  Ports       : clk           in  system clock (rising edge)
//                rst_n         in  asynchronous active-low reset
//                btn_up        in  one-clock pulse, target + 1
//                btn_down      in  one-clock pulse, target - 1
//                stop          in  level, emergency stop
//                corriente     out applied setting 0..MAX_STEP
//                corriente_set out target setting 0..MAX_STEP
//                ramping       out applied setting is moving toward target
//                at_max        out target is at MAX_STEP
//                at_min        out target is 0
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module corriente_ramp_ctrl
    import corriente_ramp_ctrl_pkg::*;
#(
    parameter int MAX_STEP = MAX_STEP_DEF,
    parameter int RAMP_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             stop,
    output logic [SET_W-1:0] corriente,
    output logic [SET_W-1:0] corriente_set,
    output logic             ramping,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [SET_W-1:0] C_MAX = SET_W'(MAX_STEP);
    localparam logic [SET_W-1:0] C_ONE = SET_W'(1);

    ramp_state_e      state_q;
    ramp_state_e      state_d;
    logic [SET_W-1:0] set_q;
    logic [SET_W-1:0] set_d;
    logic [SET_W-1:0] corr_q;
    logic [SET_W-1:0] corr_d;

    logic             w_tick;
    logic             w_tmr_en;
    logic             w_tmr_clr;

    // The timer runs only while the registered state is ramping. It is
    // cleared whenever the next state is not a ramp state, so it already
    // reads 0 on the first IDLE/STOP clock; a direction reversal keeps the
    // next state in a ramp state and therefore keeps the partial count.
    assign w_tmr_en  = is_ramp_state(state_q);
    assign w_tmr_clr = ~is_ramp_state(state_d);

    corriente_tick_gen #(
        .RAMP_DIV (RAMP_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (w_tmr_en),
        .clr_i  (w_tmr_clr),
        .tick_o (w_tick)
    );

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        corr_d  = corr_q;

        if (stop) begin
            state_d = ST_STOP;
            set_d   = '0;
            corr_d  = '0;
        end else if (state_q == ST_STOP) begin
            // Leaving STOP: settings are already 0, buttons still ignored.
            state_d = ST_IDLE;
        end else begin
            // Target update, saturating at both limits; simultaneous
            // presses cancel.
            if (btn_up && !btn_down && (set_q < C_MAX)) begin
                set_d = set_q + C_ONE;
            end else if (btn_down && !btn_up && (set_q != '0)) begin
                set_d = set_q - C_ONE;
            end

            // The step direction is taken from the registered target at the
            // step boundary, so a late target change can never push the
            // applied setting past it.
            if (w_tick) begin
                if (set_q > corr_q) begin
                    corr_d = corr_q + C_ONE;
                end else if (set_q < corr_q) begin
                    corr_d = corr_q - C_ONE;
                end
            end

            if (set_q > corr_q) begin
                state_d = ST_RAMP_UP;
            end else if (set_q < corr_q) begin
                state_d = ST_RAMP_DOWN;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            set_q   <= '0;
            corr_q  <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            corr_q  <= corr_d;
        end
    end

    assign corriente     = corr_q;
    assign corriente_set = set_q;
    assign ramping       = is_ramp_state(state_q);
    assign at_max        = (set_q == C_MAX);
    assign at_min        = (set_q == '0);

endmodule : corriente_ramp_ctrl

`default_nettype wire

// File: tb/tb_corriente_ramp_ctrl.sv
// ============================================================================
//  Module      : tb_corriente_ramp_ctrl
//  Description : Self-checking bench for corriente_ramp_ctrl (RAMP_DIV = 4).
//                Directed scenarios followed by randomized button/stop
//                traffic, all compared every clock with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_corriente_ramp_ctrl;

    localparam int RD = 4;
    localparam int MX = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       stop;
    logic [3:0] corriente;
    logic [3:0] corriente_set;
    logic       ramping;
    logic       at_max;
    logic       at_min;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: target, applied setting, step phase, and flags for
    // "moving toward target" and "coming out of an emergency stop".
    int m_set;
    int m_corr;
    int m_phase;
    bit m_moving;
    bit m_stopped;

    int trk_min;
    int trk_max;

    always #5 clk = ~clk;

    corriente_ramp_ctrl #(
        .MAX_STEP (MX),
        .RAMP_DIV (RD),
        .CNT_W    (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .stop          (stop),
        .corriente     (corriente),
        .corriente_set (corriente_set),
        .ramping       (ramping),
        .at_max        (at_max),
        .at_min        (at_min)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_set     = 0;
        m_corr    = 0;
        m_phase   = 0;
        m_moving  = 1'b0;
        m_stopped = 1'b0;
    endtask

    // One rising edge worth of behaviour, using the inputs present at the edge.
    task automatic model_clock();
        int ns, nc, nph;
        bit nmv;
        if (stop) begin
            m_set = 0; m_corr = 0; m_phase = 0; m_moving = 0; m_stopped = 1;
        end else if (m_stopped) begin
            m_phase = 0; m_moving = 0; m_stopped = 0;
        end else begin
            ns = m_set;
            if (btn_up && !btn_down && m_set < MX) ns = m_set + 1;
            else if (btn_down && !btn_up && m_set > 0) ns = m_set - 1;
            nc = m_corr;
            if (m_moving && m_phase == RD - 1) begin
                if (m_set > m_corr) nc = m_corr + 1;
                else if (m_set < m_corr) nc = m_corr - 1;
            end
            nmv = (m_set != m_corr);
            nph = !nmv ? 0 : (m_moving ? (m_phase + 1) % RD : 0);
            m_set = ns; m_corr = nc; m_phase = nph; m_moving = nmv;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".corriente"}, 32'(corriente), 32'(m_corr));
        check({tag, ".set"},       32'(corriente_set), 32'(m_set));
        check({tag, ".ramping"},   32'(ramping), 32'(m_moving));
        check({tag, ".at_max"},    32'(at_max), 32'(m_set == MX));
        check({tag, ".at_min"},    32'(at_min), 32'(m_set == 0));
    endtask

    task automatic cycle(input bit up, input bit dn, input bit st, input string tag);
        btn_up   = up;
        btn_down = dn;
        stop     = st;
        @(posedge clk);
        model_clock();
        #1;
        compare_all(tag);
        if (int'(corriente) < trk_min) trk_min = int'(corriente);
        if (int'(corriente) > trk_max) trk_max = int'(corriente);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; stop = 1'b0;
        trk_min = 99; trk_max = -1;
        model_reset();
        #12;
        compare_all("reset");
        rst_n = 1'b1;

        // 1: three up presses, ramp to 3 with RD-clock spacing
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, "t1.press");
        check("t1.set_after_presses", 32'(corriente_set), 32'd3);
        idle(20, "t1.ramp");
        check("t1.final_corr", 32'(corriente), 32'd3);
        check("t1.final_ramping", 32'(ramping), 32'd0);

        // 2: saturation at both limits
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0, "t2.up");
        check("t2.set_sat_max", 32'(corriente_set), 32'd10);
        check("t2.at_max", 32'(at_max), 32'd1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, "t2.down");
        check("t2.set_sat_min", 32'(corriente_set), 32'd0);
        check("t2.at_min", 32'(at_min), 32'd1);
        idle(60, "t2.settle");
        check("t2.corr_zero", 32'(corriente), 32'd0);

        // 3: simultaneous presses cancel
        cycle(1'b1, 1'b0, 1'b0, "t3.pre");
        cycle(1'b1, 1'b0, 1'b0, "t3.pre");
        idle(15, "t3.settle");
        cycle(1'b1, 1'b1, 1'b0, "t3.both");
        check("t3.set_unchanged", 32'(corriente_set), 32'd2);
        idle(2, "t3.after");
        check("t3.state_idle", 32'(ramping), 32'd0);

        // 4: reversal mid-ramp, target 6 then 1
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, "t4.up");
        for (int i = 0; i < 40 && corriente != 4'd3; i++) cycle(1'b0, 1'b0, 1'b0, "t4.wait");
        check("t4.reached3", 32'(corriente), 32'd3);
        trk_min = 99; trk_max = -1;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, "t4.down");
        idle(40, "t4.settle");
        check("t4.final_corr", 32'(corriente), 32'd1);
        check("t4.never_above6", 32'(trk_max <= 6), 32'd1);
        check("t4.never_below1", 32'(trk_min >= 1), 32'd1);

        // 5: emergency stop at corriente = 7
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, "t5.up");
        for (int i = 0; i < 60 && corriente != 4'd7; i++) cycle(1'b0, 1'b0, 1'b0, "t5.wait");
        check("t5.reached7", 32'(corriente), 32'd7);
        cycle(1'b0, 1'b0, 1'b1, "t5.stop");
        check("t5.corr_zero", 32'(corriente), 32'd0);
        check("t5.set_zero", 32'(corriente_set), 32'd0);
        cycle(1'b1, 1'b0, 1'b1, "t5.btn_in_stop");
        cycle(1'b1, 1'b0, 1'b1, "t5.btn_in_stop");
        check("t5.set_ignored", 32'(corriente_set), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, "t5.release");
        check("t5.release_set", 32'(corriente_set), 32'd0);
        check("t5.release_idle", 32'(ramping), 32'd0);
        idle(3, "t5.after");

        // 6: asynchronous reset between edges mid-ramp
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, "t6.up");
        idle(6, "t6.ramp");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("t6.async");
        check("t6.ramping_clear", 32'(ramping), 32'd0);
        #2;
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 79) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_corriente_ramp_ctrl

`default_nettype wire
